// File: rtl/vx_rr_lzc_arbiter_if.sv
// Request/grant bundle for vx_rr_lzc_arbiter.
// The master is the requester/consumer side; the slave is the arbiter itself.
interface vx_rr_lzc_arbiter_if #(
    parameter int N    = 2,
    parameter int LOGN = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]    data_in;
    logic            lock_in;
    logic            ready_in;
    logic [LOGN-1:0] data_out;
    logic [N-1:0]    onehot_out;
    logic            valid_out;
    logic            locked_out;

    modport master (
        output data_in, lock_in, ready_in,
        input  data_out, onehot_out, valid_out, locked_out
    );

    modport slave (
        input  data_in, lock_in, ready_in,
        output data_out, onehot_out, valid_out, locked_out
    );
endinterface

// File: rtl/vx_rr_lzc_arbiter.sv
// Round-robin first-set picker with valid/ready handshake and optional grant lock.
// The rotating pointer only moves on an accepted grant, so fairness counts transfers.
module vx_rr_lzc_arbiter #(
    parameter int N           = 2,
    parameter int REVERSE     = 0,
    parameter int LOCK_ENABLE = 0,
    parameter int LOGN        = (N > 1) ? $clog2(N) : 1
) (
    input logic                clk,
    input logic                reset,
    vx_rr_lzc_arbiter_if.slave bus
);
    localparam int NP = 1 << LOGN;
    typedef logic [LOGN:0] ext_t;
    localparam ext_t N_EXT = ext_t'(N);

    logic [LOGN-1:0] ptr_q, ptr_d;
    logic            locked_q, locked_d;
    logic [LOGN-1:0] lock_idx_q, lock_idx_d;

    logic [NP-1:0]   req_pad;
    logic            scan_found;
    logic [LOGN-1:0] scan_idx;
    logic            use_lock;
    logic [LOGN-1:0] grant;
    logic            valid;
    logic            fire;

    // Padding to a power of two keeps every index exact-width, including N==1.
    assign req_pad = NP'(bus.data_in);

    // Position k steps from base in scan order, modulo N, computed on LOGN+1 bits.
    function automatic logic [LOGN-1:0] scan_pos(input logic [LOGN-1:0] base, input ext_t k);
        ext_t b;
        ext_t r;
        b = {1'b0, base};
        if (REVERSE == 0) begin
            r = b + k;
            if (r >= N_EXT) r = r - N_EXT;
        end else begin
            if (k > b) r = b + N_EXT - k;
            else       r = b - k;
        end
        return r[LOGN-1:0];
    endfunction

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!scan_found && req_pad[scan_pos(ptr_q, ext_t'(k))]) begin
                scan_found = 1'b1;
                scan_idx   = scan_pos(ptr_q, ext_t'(k));
            end
        end
    end

    assign use_lock = locked_q && req_pad[lock_idx_q];
    assign grant    = use_lock ? lock_idx_q : scan_idx;
    assign valid    = |bus.data_in;
    assign fire     = valid && bus.ready_in;

    assign bus.valid_out  = valid;
    assign bus.data_out   = valid ? grant : '0;
    assign bus.onehot_out = valid ? (N'(1) << grant) : '0;
    assign bus.locked_out = locked_q;

    // A fire overrides a same-cycle lock release, so a fresh lock can be taken at once.
    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (locked_q && !req_pad[lock_idx_q]) locked_d = 1'b0;
        if (fire) begin
            ptr_d = scan_pos(grant, ext_t'(1));
            if ((LOCK_ENABLE != 0) && bus.lock_in) begin
                locked_d   = 1'b1;
                lock_idx_d = grant;
            end else begin
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifndef SYNTHESIS
    a_onehot0: assert property (@(posedge clk) $onehot0(bus.onehot_out));
    a_granted: assert property (@(posedge clk) bus.valid_out |-> req_pad[bus.data_out]);
`endif
endmodule

// File: tb/tb_vx_rr_lzc_arbiter.sv
// Directed bench for vx_rr_lzc_arbiter: N=4 with lock, N=5 reverse scan, N=1 corner.
module tb_vx_rr_lzc_arbiter;
    logic clk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    vx_rr_lzc_arbiter_if #(.N(4)) bus4 ();
    vx_rr_lzc_arbiter_if #(.N(5)) bus5 ();
    vx_rr_lzc_arbiter_if #(.N(1)) bus1 ();

    vx_rr_lzc_arbiter #(.N(4), .REVERSE(0), .LOCK_ENABLE(1)) u4 (
        .clk(clk), .reset(rst), .bus(bus4.slave)
    );
    vx_rr_lzc_arbiter #(.N(5), .REVERSE(1), .LOCK_ENABLE(0)) u5 (
        .clk(clk), .reset(rst), .bus(bus5.slave)
    );
    vx_rr_lzc_arbiter #(.N(1), .REVERSE(0), .LOCK_ENABLE(1)) u1 (
        .clk(clk), .reset(rst), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned exp1 [5] = '{0, 1, 2, 3, 0};
        int unsigned exp3 [4] = '{0, 4, 0, 4};
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus4.data_in = '0; bus4.lock_in = 1'b0; bus4.ready_in = 1'b0;
        bus5.data_in = '0; bus5.lock_in = 1'b0; bus5.ready_in = 1'b0;
        bus1.data_in = '0; bus1.lock_in = 1'b0; bus1.ready_in = 1'b0;
        tick;
        tick;

        // reset state: ptr 0, no lock
        bus4.data_in = 4'b1111;
        #1;
        check_eq("rst_out", 32'(bus4.data_out), 0);
        check_eq("rst_valid", 32'(bus4.valid_out), 1);
        check_eq("rst_locked", 32'(bus4.locked_out), 0);
        rst = 1'b0;

        // 1: full request, always ready
        bus4.ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t1_out", 32'(bus4.data_out), exp1[i]);
            check_eq("t1_onehot", 32'(bus4.onehot_out), 32'(1) << exp1[i]);
            tick;
        end

        // 2: stall holds the grant, then pointer moves on accept
        bus4.data_in  = 4'b1010;
        bus4.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_hold", 32'(bus4.data_out), 1);
            tick;
        end
        bus4.ready_in = 1'b1;
        #1;
        check_eq("t2_fire1", 32'(bus4.data_out), 1);
        tick;
        #1;
        check_eq("t2_fire3", 32'(bus4.data_out), 3);
        tick;
        bus4.ready_in = 1'b0;
        #1;
        check_eq("t2_ptr0", 32'(bus4.data_out), 1);

        // 4: lock holds index 0 across fires
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus4.data_in  = 4'b1111;
        bus4.lock_in  = 1'b1;
        bus4.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus4.lock_in = 1'b0;
            #1;
            check_eq("t4_out", 32'(bus4.data_out), 0);
            check_eq("t4_locked", 32'(bus4.locked_out), (i > 0) ? 1 : 0);
            tick;
        end
        bus4.ready_in = 1'b0;
        #1;
        check_eq("t4_after", 32'(bus4.data_out), 1);
        check_eq("t4_unlocked", 32'(bus4.locked_out), 0);

        // 5: lock on 2, then requester 2 drops without a fire
        bus4.data_in  = 4'b0100;
        bus4.lock_in  = 1'b1;
        bus4.ready_in = 1'b1;
        #1;
        check_eq("t5_grant2", 32'(bus4.data_out), 2);
        tick;
        bus4.lock_in  = 1'b0;
        bus4.ready_in = 1'b0;
        bus4.data_in  = 4'b1001;
        #1;
        check_eq("t5_still_locked", 32'(bus4.locked_out), 1);
        check_eq("t5_out_now", 32'(bus4.data_out), 3);
        tick;
        #1;
        check_eq("t5_released", 32'(bus4.locked_out), 0);
        check_eq("t5_out_next", 32'(bus4.data_out), 3);

        // 6: no request with ready, then reset while locked
        bus4.data_in  = 4'b0000;
        bus4.ready_in = 1'b1;
        #1;
        check_eq("t6_valid", 32'(bus4.valid_out), 0);
        check_eq("t6_out", 32'(bus4.data_out), 0);
        check_eq("t6_onehot", 32'(bus4.onehot_out), 0);
        tick;
        bus4.data_in  = 4'b1111;
        bus4.ready_in = 1'b0;
        #1;
        check_eq("t6_ptr_kept", 32'(bus4.data_out), 3);
        bus4.lock_in  = 1'b1;
        bus4.ready_in = 1'b1;
        tick;
        bus4.lock_in  = 1'b0;
        bus4.ready_in = 1'b0;
        #1;
        check_eq("t6_locked", 32'(bus4.locked_out), 1);
        check_eq("t6_lock_out", 32'(bus4.data_out), 3);
        rst = 1'b1;
        tick;
        #1;
        check_eq("t6_rst_locked", 32'(bus4.locked_out), 0);
        check_eq("t6_rst_out", 32'(bus4.data_out), 0);
        rst = 1'b0;

        // 3: N=5 downward scan wraps 0 -> 4
        bus5.data_in  = 5'b10001;
        bus5.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t3_out", 32'(bus5.data_out), exp3[i]);
            check_eq("t3_onehot", 32'(bus5.onehot_out), 32'(1) << exp3[i]);
            tick;
        end
        bus5.ready_in = 1'b0;
        bus5.data_in  = 5'b00110;
        #1;
        check_eq("t3_down_scan", 32'(bus5.data_out), 2);

        // single-requester instance
        #1;
        check_eq("n1_idle_valid", 32'(bus1.valid_out), 0);
        check_eq("n1_idle_onehot", 32'(bus1.onehot_out), 0);
        bus1.data_in = 1'b1;
        #1;
        check_eq("n1_out", 32'(bus1.data_out), 0);
        check_eq("n1_onehot", 32'(bus1.onehot_out), 1);
        check_eq("n1_valid", 32'(bus1.valid_out), 1);
        bus1.lock_in  = 1'b1;
        bus1.ready_in = 1'b1;
        tick;
        bus1.lock_in  = 1'b0;
        bus1.ready_in = 1'b0;
        #1;
        check_eq("n1_locked", 32'(bus1.locked_out), 1);
        bus1.data_in = 1'b0;
        tick;
        #1;
        check_eq("n1_released", 32'(bus1.locked_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
